// File: rtl/axi4lite_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ
// requesters, with a single transaction in flight at a time.
module axi4lite_master_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  PROT_VAL   = 3'b000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              AWVALID,
    output logic [ADDR_WIDTH-1:0]             AWADDR,
    output logic [2:0]                        AWPROT,
    input  logic                              AWREADY,
    output logic                              WVALID,
    output logic [DATA_WIDTH-1:0]             WDATA,
    output logic [DATA_WIDTH/8-1:0]           WSTRB,
    input  logic                              WREADY,
    output logic                              BREADY,
    input  logic                              BVALID,
    input  logic [1:0]                        BRESP,
    output logic                              ARVALID,
    output logic [ADDR_WIDTH-1:0]             ARADDR,
    output logic [2:0]                        ARPROT,
    input  logic                              ARREADY,
    output logic                              RREADY,
    input  logic                              RVALID,
    input  logic [DATA_WIDTH-1:0]             RDATA,
    input  logic [1:0]                        RRESP
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]          wstrb_q, wstrb_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;

    logic                   arb_found;
    logic [GW-1:0]          arb_idx;
    logic [GW-1:0]          cand;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
    logic [SW-1:0]          wstrb_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_arr[i] = req_wstrb[i*SW +: SW];
    end

    // Search starts one past the last granted requester and wraps around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where VALID and READY are
    // both high; a VALID, once raised, stays high with stable payload until then.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    req_ready[arb_idx] = 1'b1;
                    grant_d   = arb_idx;
                    addr_d    = addr_arr[arb_idx];
                    wdata_d   = wdata_arr[arb_idx];
                    wstrb_d   = wstrb_arr[arb_idx];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write[arb_idx] ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (AWVALID && AWREADY) aw_done_d = 1'b1;
                if (WVALID && WREADY)   w_done_d  = 1'b1;
                if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BVALID) begin
                    resp_d  = BRESP;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RD_REQ: begin
                if (ARREADY) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    resp_d  = RRESP;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
    end

    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_resp  = (state_q == RESP) ? resp_q  : 2'b00;

    assign AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign BREADY  = (state_q == WR_RESP);
    assign ARVALID = (state_q == RD_REQ);
    assign RREADY  = (state_q == RD_RESP);
    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign AWPROT  = PROT_VAL;
    assign ARPROT  = PROT_VAL;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Directed bench for axi4lite_master_arbiter: a negedge slave model, a driver task
// per requester command, and a scoreboard monitor that checks every rsp_valid pulse.
module tb_axi4lite_master_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = NR + DW + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*SW-1:0] req_wstrb = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic [1:0]       rsp_resp;
    logic             AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [AW-1:0]    AWADDR, ARADDR;
    logic [2:0]       AWPROT, ARPROT;
    logic [DW-1:0]    WDATA;
    logic [SW-1:0]    WSTRB;
    logic             AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [1:0]       BRESP, RRESP;
    logic [DW-1:0]    RDATA;

    axi4lite_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_VAL(3'b000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];
    int grant_log[$];
    int rsp_cyc_q[$];
    int acc_cyc[NR];

    // slave configuration
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [DW-1:0] r_data_cfg = '0;
    logic [1:0]    r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    // channel observation
    int aw_hi, w_hi, aw_first, w_first, aw_unstable, bready_early;
    logic [AW-1:0] aw_prev, ar_addr_seen;

    assign RDATA = r_data_cfg;
    assign RRESP = r_resp_cfg;
    assign BRESP = b_resp_cfg;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: READY/VALID after a configurable number of waiting cycles.
    always @(negedge clk) begin
        if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; end
        else begin AWREADY = 1'b0; aw_wait = 0; end
        if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; end
        else begin WREADY = 1'b0; w_wait = 0; end
        if (BREADY) begin BVALID = (b_wait >= b_dly); b_wait++; end
        else begin BVALID = 1'b0; b_wait = 0; end
        if (ARVALID) begin ARREADY = (ar_wait >= ar_dly); ar_wait++; end
        else begin ARREADY = 1'b0; ar_wait = 0; end
        if (RREADY) begin RVALID = (r_wait >= r_dly); r_wait++; end
        else begin RVALID = 1'b0; r_wait = 0; end
    end

    // Monitor: channel observation plus scoreboard pop on every response pulse.
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (!reset) begin
            if (!$onehot0(req_ready)) begin
                fails++;
                $display("FAIL req_ready_onehot: got %b, required at most one bit", req_ready);
            end
            if (AWVALID) begin
                if (aw_first < 0) aw_first = cyc;
                if (aw_hi > 0 && AWADDR !== aw_prev) aw_unstable++;
                aw_prev = AWADDR;
                aw_hi++;
            end
            if (WVALID) begin
                if (w_first < 0) w_first = cyc;
                w_hi++;
            end
            if (BREADY && (AWVALID || WVALID)) bready_early++;
            if (ARVALID) ar_addr_seen = ARADDR;
            if (rsp_valid != '0) begin
                tests++;
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b, required no response", rsp_valid);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rsp_valid, rsp_rdata, rsp_resp} !== exp) begin
                        fails++;
                        $display("FAIL rsp_match: got valid=%b rdata=0x%h resp=%b, required valid=%b rdata=0x%h resp=%b",
                                 rsp_valid, rsp_rdata, rsp_resp, exp[EW-1 -: NR], exp[DW+1:2], exp[1:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic clear_obs();
        aw_hi = 0; w_hi = 0; aw_first = -1; w_first = -1;
        aw_unstable = 0; bready_early = 0; aw_prev = '0; ar_addr_seen = '0;
        rsp_cyc_q.delete();
        grant_log.delete();
    endtask

    task automatic issue(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input bit hold, input bit push,
                         input logic [DW-1:0] e_rdata, input logic [1:0] e_resp);
        bit got;
        logic [NR-1:0] oh;
        got = 1'b0;
        @(negedge clk);
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_wstrb[r*SW +: SW] = s;
        req_valid[r] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            #1;
            if (req_ready[r]) begin
                got = 1'b1;
                acc_cyc[r] = cyc;
                grant_log.push_back(r);
                if (push) begin
                    oh = '0;
                    oh[r] = 1'b1;
                    exp_q.push_back({oh, e_rdata, e_resp});
                end
                @(posedge clk);
                if (!hold) begin #1; req_valid[r] = 1'b0; end
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL accept_timeout: requester %0d got no req_ready, required acceptance", r);
            req_valid[r] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        clear_obs();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_handshake_outs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, req_ready}, 0);
        check("reset_rsp_data", {rsp_rdata, rsp_resp}, 0);
        check("reset_awaddr_araddr", {AWADDR, ARADDR}, 0);
        check("reset_wdata_wstrb", {WDATA, WSTRB}, 0);
        reset = 1'b0;

        // 1: single write, slave ready immediately
        clear_obs();
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0, 2'b00);
        drain();
        check("t1_aw_latency", aw_first, acc_cyc[0] + 1);
        check("t1_w_latency", w_first, acc_cyc[0] + 1);
        check("t1_aw_cycles", aw_hi, 1);

        // 2: AWREADY delayed 3 cycles, WREADY immediate
        clear_obs();
        aw_dly = 3;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0, 2'b00);
        drain();
        aw_dly = 0;
        check("t2_aw_cycles", aw_hi, 4);
        check("t2_w_cycles", w_hi, 1);
        check("t2_awaddr_stable", aw_unstable, 0);
        check("t2_bready_after_aw", bready_early, 0);

        // 3: both requesters held valid from reset; DECERR write response passes through
        pulse_reset();
        clear_obs();
        b_resp_cfg = 2'b11;
        r_data_cfg = 32'hCAFE0001;
        fork
            begin
                issue(0, 1'b1, 32'h100, 32'h11111111, 4'h3, 1'b1, 1'b1, 32'h0, 2'b11);
                issue(0, 1'b1, 32'h104, 32'h22222222, 4'hC, 1'b0, 1'b1, 32'h0, 2'b11);
            end
            begin
                issue(1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFE0001, 2'b00);
                issue(1, 1'b0, 32'h204, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE0001, 2'b00);
            end
        join
        drain();
        b_resp_cfg = 2'b00;
        check("t3_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("t3_grant_order", grant_log[i], exp_g[i]);

        // 4: req1 read, RVALID 5 cycles after the AR handshake, SLVERR
        clear_obs();
        r_dly = 4;
        r_data_cfg = 32'h12345678;
        r_resp_cfg = 2'b10;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, 2'b10);
        drain();
        check("t4_araddr", ar_addr_seen, 32'h20);
        check("t4_rsp_latency", (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] : -1, acc_cyc[1] + 7);

        // 5: reset while waiting in RD_RESP
        clear_obs();
        r_dly = 50;
        issue(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        repeat (2) @(negedge clk);
        check("t5_in_rd_resp", RREADY, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_outs_after_reset", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
        reset = 1'b0;
        r_dly = 0;
        r_resp_cfg = 2'b00;
        r_data_cfg = 32'hA5A50000;
        repeat (3) @(negedge clk);
        check("t5_no_response", rsp_cyc_q.size(), 0);
        grant_log.delete();
        fork
            issue(0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0, 1'b1, 32'h0, 2'b00);
            issue(1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A50000, 2'b00);
        join
        drain();
        check("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // 6: req1 arrives while req0's write is in flight
        clear_obs();
        fork
            issue(0, 1'b1, 32'h50, 32'h55AA55AA, 4'h5, 1'b0, 1'b1, 32'h0, 2'b00);
            begin
                repeat (2) @(negedge clk);
                issue(1, 1'b0, 32'h54, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A50000, 2'b00);
            end
        join
        drain();
        check("t6_grant_order", (grant_log.size() == 2) ? {grant_log[0][7:0], grant_log[1][7:0]} : 16'hFFFF, 16'h0001);
        check("t6_accept_after_resp", acc_cyc[1], ((rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] : -10) + 1);
        check("t6_accept_spacing", acc_cyc[1], acc_cyc[0] + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
